// File: rtl/key_enc_pkg.sv
// Shared types and helpers for the four-line active-low key encoder.
package key_enc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HELD
  } state_t;

  localparam logic [1:0] KEY0 = 2'd0;
  localparam logic [1:0] KEY1 = 2'd1;
  localparam logic [1:0] KEY2 = 2'd2;
  localparam logic [1:0] KEY3 = 2'd3;

  // Lowest-index active (zero) line wins.
  function automatic logic [1:0] pri_enc(input logic [3:0] d);
    if (!d[0])      pri_enc = KEY0;
    else if (!d[1]) pri_enc = KEY1;
    else if (!d[2]) pri_enc = KEY2;
    else            pri_enc = KEY3;
  endfunction

  function automatic logic multi_zero(input logic [3:0] d);
    multi_zero = ($countones(~d) > 1);
  endfunction

endpackage

// File: rtl/key_deb.sv
// Two-flop synchroniser plus debouncer for four active-low request lines.
module key_deb
  import key_enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] line_n,
  output logic [3:0] deb
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       last;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '1;
      s2   <= '1;
      last <= '1;
      deb  <= '1;
      cnt  <= '0;
    end else begin
      s1 <= line_n;
      s2 <= s1;
      // cnt saturates at CNT_MAX so a long hold keeps reloading deb harmlessly
      if (s2 != last) begin
        last <= s2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        deb <= last;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_enc.sv
// Four-line key encoder: debounced one-hot presses become 2-bit code events
// on a valid/ready handshake. Optional multi-key rejection: MULTI_KEY_DETECT_EN.
module key_enc
  import key_enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] line_n,
  output logic [1:0] code_out,
  output logic       valid,
  input  logic       ready,
  output logic       multi
);

  logic [3:0] deb;
  state_t     state;

  key_deb #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb (
    .clk   (clk),
    .rst   (rst),
    .line_n(line_n),
    .deb   (deb)
  );

`ifdef MULTI_KEY_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code_out <= KEY0;
      valid    <= 1'b0;
      multi    <= 1'b0;
    end else begin
      multi <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (multi_zero(deb)) begin
              multi <= 1'b1;
              state <= HELD;
            end else if (deb != '1) begin
              code_out <= pri_enc(deb);
              valid    <= 1'b1;
              state    <= PEND;
            end
          end
          PEND: begin
            if (ready) begin
              valid <= 1'b0;
              state <= HELD;
            end
          end
          HELD:    if (deb == '1) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
`else
  assign multi = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code_out <= KEY0;
      valid    <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (deb != '1) begin
            code_out <= pri_enc(deb);
            valid    <= 1'b1;
            state    <= PEND;
          end
        end
        PEND: begin
          if (ready) begin
            valid <= 1'b0;
            state <= HELD;
          end
        end
        HELD:    if (deb == '1) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
